multiplier: RTL and testbench

- Iterative radix-2 shift-add multiplier for the M-extension unit; the multiply counterpart of the sequential divider.
- Sits beside the divider in the execute stage and uses the same start/done pulse handshake.
- Implements MUL, MULH, MULHSU and MULHU.
- Internally works on operand magnitudes, with a final two's-complement sign fix-up.

---
 rtl/multiplier.sv | 170 +++++++++++++++++
 tb/tb_multiplier.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
//   Iterative radix-2 shift-add multiplier for the M-extension unit. It
//   implements MUL, MULH, MULHSU and MULHU. It sits beside the sequential
//   divider and uses the same start/done pulse handshake. The datapath works
//   on operand magnitudes. A single two's-complement fix-up at the end applies
//   the sign of the product.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-low reset
//   start_i  start request, sampled only while idle
//   kill_i   pipeline flush, aborts any operation in progress
//   op_i     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (captured with start_i)
//   opr1_i   multiplicand (rs1), captured with start_i
//   opr2_i   multiplier (rs2), captured with start_i
//   done_o   one-cycle result-valid pulse
//   busy_o   high while iterating or fixing up the sign
//   res_o    result, held until the next completed operation
// -----------------------------------------------------------------------------
module multiplier #(
    parameter int XLEN = 32  // keep in step with the core-wide XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] opr1_i,
    input  logic [XLEN-1:0] opr2_i,
    output logic            done_o,
    output logic            busy_o,
    output logic [XLEN-1:0] res_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE0
    } state_e;

    state_e            state_q,  state_d;
    logic [1:0]        op_q,     op_d;
    logic [XLEN-1:0]   mcand_q,  mcand_d;   // multiplicand magnitude
    logic [XLEN-1:0]   mplier_q, mplier_d;  // multiplier magnitude, consumed LSB first
    logic [2*XLEN-1:0] acc_q,    acc_d;     // product accumulator
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic              neg_q,    neg_d;
    logic              done_q,   done_d;
    logic [XLEN-1:0]   res_q,    res_d;

    // Operand signedness and magnitudes. The most negative value negates to
    // itself, and read as unsigned that is already the correct magnitude.
    logic            opr1_neg, opr2_neg;
    logic [XLEN-1:0] mag1, mag2;

    always_comb begin
        opr1_neg = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && opr1_i[XLEN-1];
        opr2_neg = (op_i == OP_MULH) && opr2_i[XLEN-1];
        mag1     = opr1_neg ? -opr1_i : opr1_i;
        mag2     = opr2_neg ? -opr2_i : opr2_i;
    end

    // One shift-add step. The add is one bit wider than XLEN, so the carry
    // out of the upper half moves into the top bit during the right shift.
    logic [XLEN:0]     step_sum;
    logic [2*XLEN-1:0] product;

    always_comb begin
        step_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        product  = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path
        // through the case statement can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        res_d    = res_q;

        unique case (state_q)
            IDLE: begin
                if (start_i && !kill_i) begin
                    op_d     = op_i;
                    mcand_d  = mag1;
                    mplier_d = mag2;
                    neg_d    = opr1_neg ^ opr2_neg;
                    acc_d    = '0;
                    cnt_d    = '0;
                    // A zero operand forces a zero product. This skips the iterations.
                    state_d  = ((opr1_i == '0) || (opr2_i == '0)) ? DONE0 : CALC;
                end
            end
            CALC: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = {step_sum, acc_q[XLEN-1:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!kill_i) begin
                    res_d  = (op_q == OP_MUL) ? product[XLEN-1:0]
                                              : product[2*XLEN-1:XLEN];
                    done_d = 1'b1;
                end
            end
            DONE0: begin
                state_d = IDLE;
                if (!kill_i) begin
                    res_d  = '0;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every register
    // samples the values that were current before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            res_q    <= res_d;
        end
    end

    assign done_o = done_q;
    assign busy_o = (state_q == CALC) || (state_q == FIX);
    assign res_o  = res_q;

endmodule

// File: tb/tb_multiplier.sv
// -----------------------------------------------------------------------------
// tb_multiplier
//   Self-checking bench for the iterative multiplier. Results are compared
//   against a behavioural model that forms the full signed/unsigned product
//   with plain arithmetic. The bench also checks latency, busy duration,
//   kill, asynchronous reset and back-to-back starts.
// -----------------------------------------------------------------------------
module tb_multiplier;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic            kill_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] opr1_i;
    logic [XLEN-1:0] opr2_i;
    logic            done_o;
    logic            busy_o;
    logic [XLEN-1:0] res_o;

    int checks = 0;
    int errors = 0;

    multiplier #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .kill_i  (kill_i),
        .op_i    (op_i),
        .opr1_i  (opr1_i),
        .opr2_i  (opr2_i),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .res_o   (res_o)
    );

    always #5 clk = ~clk;

    // Reference model: sign- or zero-extend both operands, multiply exactly,
    // then select the requested half of the product.
    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic signed [2*XLEN+1:0] sa, sb, p;
        sa = (op == 2'b01 || op == 2'b10) ? {{(XLEN+2){a[XLEN-1]}}, a}
                                          : {{(XLEN+2){1'b0}}, a};
        sb = (op == 2'b01) ? {{(XLEN+2){b[XLEN-1]}}, b}
                           : {{(XLEN+2){1'b0}}, b};
        p  = sa * sb;
        return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    function automatic int ref_latency(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return (a == '0 || b == '0) ? 2 : XLEN + 2;
    endfunction

    // Issue one operation and wait (bounded) for done_o. The returned latency
    // counts cycles from the edge that sampled start_i.
    task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, output logic [XLEN-1:0] res,
                          output int lat, output int busy_cnt, output bit timeout);
        @(negedge clk);
        start_i = 1'b1; op_i = op; opr1_i = a; opr2_i = b;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1; busy_cnt = 0; timeout = 1'b0;
        while (done_o !== 1'b1) begin
            if (busy_o === 1'b1) busy_cnt++;
            if (lat >= 100) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        res = res_o;
    endtask

    task automatic test_reset();
        rst = 1'b0; start_i = 1'b0; kill_i = 1'b0; op_i = '0; opr1_i = '0; opr2_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({done_o, busy_o, res_o} !== {1'b0, 1'b0, {XLEN{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: done=%b busy=%b res=%h, expected 0/0/0", done_o, busy_o, res_o);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_basic();
        logic [XLEN-1:0] res; int lat, bcnt; bit to;
        run_op(2'b00, 32'd7, 32'd6, res, lat, bcnt, to);
        checks++;
        if (to || res !== 32'h0000002A) begin
            errors++;
            $display("FAIL mul_7x6: res=%h timeout=%0d, expected 0000002a", res, to);
        end
        checks++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL mul_latency: got %0d cycles, expected 34", lat);
        end
        checks++;
        if (bcnt !== 33) begin
            errors++;
            $display("FAIL busy_length: got %0d cycles, expected 33", bcnt);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || res_o !== 32'h0000002A) begin
            errors++;
            $display("FAIL done_pulse_width: done=%b res=%h, expected 0 / 0000002a", done_o, res_o);
        end
    endtask

    // Corner operand table covering every op code and the sign extremes.
    task automatic test_corners();
        logic [1:0]      ops [7] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10};
        logic [XLEN-1:0] as  [7] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [XLEN-1:0] bs  [7] = '{32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003};
        logic [XLEN-1:0] res; int lat, bcnt; bit to;
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, bcnt, to);
            checks++;
            if (to || res !== ref_mul(ops[i], as[i], bs[i])) begin
                errors++;
                $display("FAIL corner_%0d op=%b %h x %h: res=%h timeout=%0d, expected %h",
                         i, ops[i], as[i], bs[i], res, to, ref_mul(ops[i], as[i], bs[i]));
            end
        end
    endtask

    task automatic test_early_out();
        logic [XLEN-1:0] res; int lat, bcnt; bit to;
        run_op(2'b00, 32'd0, 32'h1234, res, lat, bcnt, to);
        checks++;
        if (to || res !== '0 || lat !== 2) begin
            errors++;
            $display("FAIL early_out_opr1: res=%h lat=%0d timeout=%0d, expected 0 in 2 cycles", res, lat, to);
        end
        run_op(2'b01, 32'hDEAD_BEEF, 32'd0, res, lat, bcnt, to);
        checks++;
        if (to || res !== '0 || lat !== 2 || bcnt !== 0) begin
            errors++;
            $display("FAIL early_out_opr2: res=%h lat=%0d busy=%0d, expected 0 in 2 cycles, busy 0", res, lat, bcnt);
        end
    endtask

    task automatic test_start_ignored();
        int lat = 1;
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; opr1_i = 32'h1234; opr2_i = 32'h10;
        @(negedge clk);
        start_i = 1'b0;
        while (done_o !== 1'b1 && lat < 100) begin
            if (lat == 6) begin
                start_i = 1'b1; op_i = 2'b11; opr1_i = '1; opr2_i = '1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || res_o !== ref_mul(2'b00, 32'h1234, 32'h10) || lat !== 34) begin
            errors++;
            $display("FAIL start_during_calc: res=%h lat=%0d, expected %h in 34",
                     res_o, lat, ref_mul(2'b00, 32'h1234, 32'h10));
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_no_restart: busy=%b done=%b, expected 0/0", busy_o, done_o);
        end
    endtask

    task automatic test_kill();
        logic [XLEN-1:0] res; int lat, bcnt; bit to; bit saw_done = 1'b0;
        run_op(2'b00, 32'd7, 32'd6, res, lat, bcnt, to);
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; opr1_i = 32'd3; opr2_i = 32'd5;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || res_o !== ref_mul(2'b00, 32'd7, 32'd6)) begin
            errors++;
            $display("FAIL kill_abort: busy=%b done=%b res=%h, expected 0/0/%h",
                     busy_o, done_o, res_o, ref_mul(2'b00, 32'd7, 32'd6));
        end
        repeat (40) begin
            @(negedge clk);
            if (done_o === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL kill_no_done: done pulsed after kill, expected none");
        end
        // kill together with start in IDLE must not start an operation.
        start_i = 1'b1; kill_i = 1'b1; opr1_i = 32'd9; opr2_i = 32'd9;
        @(negedge clk);
        start_i = 1'b0; kill_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL kill_blocks_start: busy=%b, expected 0", busy_o);
        end
        run_op(2'b00, 32'd3, 32'd5, res, lat, bcnt, to);
        checks++;
        if (to || res !== 32'h0000000F) begin
            errors++;
            $display("FAIL mul_after_kill: res=%h timeout=%0d, expected 0000000f", res, to);
        end
    endtask

    task automatic test_async_reset();
        bit saw_done = 1'b0;
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; opr1_i = 32'd9; opr2_i = 32'd9;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || res_o !== '0) begin
            errors++;
            $display("FAIL async_reset: done=%b busy=%b res=%h, expected 0/0/0 before any edge",
                     done_o, busy_o, res_o);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done_o === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || res_o !== '0) begin
            errors++;
            $display("FAIL reset_discards_op: saw_done=%0d res=%h, expected no done, res 0", saw_done, res_o);
        end
    endtask

    task automatic test_back_to_back();
        int gap = 0;
        int wait_cnt = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b11; opr1_i = 32'hCAFE_0001; opr2_i = 32'h0BAD_F00D;
        while (done_o !== 1'b1 && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (done_o !== 1'b1 || res_o !== ref_mul(2'b11, 32'hCAFE_0001, 32'h0BAD_F00D)) begin
            errors++;
            $display("FAIL b2b_first: res=%h done=%b, expected %h",
                     res_o, done_o, ref_mul(2'b11, 32'hCAFE_0001, 32'h0BAD_F00D));
        end
        op_i = 2'b01; opr1_i = 32'hF000_0003; opr2_i = 32'h7654_3210;
        do begin
            @(negedge clk);
            gap++;
        end while (done_o !== 1'b1 && gap < 100);
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || gap !== 34 || res_o !== ref_mul(2'b01, 32'hF000_0003, 32'h7654_3210)) begin
            errors++;
            $display("FAIL b2b_second: res=%h gap=%0d, expected %h with gap 34",
                     res_o, gap, ref_mul(2'b01, 32'hF000_0003, 32'h7654_3210));
        end
        @(negedge clk);
    endtask

    function automatic logic [XLEN-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [XLEN-1:0] a, b, res; logic [1:0] op; int lat, bcnt; bit to;
        for (int i = 0; i < 40; i++) begin
            a  = pick_operand();
            b  = pick_operand();
            op = 2'($urandom_range(0, 3));
            run_op(op, a, b, res, lat, bcnt, to);
            checks++;
            if (to || res !== ref_mul(op, a, b) || lat !== ref_latency(a, b)) begin
                errors++;
                $display("FAIL random_%0d op=%b %h x %h: res=%h lat=%0d, expected %h lat=%0d",
                         i, op, a, b, res, lat, ref_mul(op, a, b), ref_latency(a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_corners();
        test_early_out();
        test_start_ignored();
        test_kill();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
